// File: rtl/pipe_ctrl_n_pkg.sv
// Shared definitions for the pipe_ctrl_n pipeline control unit:
// FSM encodings, boolean constants, default stage indices and a width helper.
package pipe_ctrl_n_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Default stage indices of the classic 5-stage core (0 = youngest).
    typedef enum int {
        STG_IF  = 0,
        STG_ID  = 1,
        STG_EX  = 2,
        STG_MEM = 3,
        STG_WB  = 4
    } stage_e;

    // Bits needed to hold a counter value 0..max (at least one bit).
    function automatic int cnt_width(input int max);
        return (max <= 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_n_if.sv
// Request/response bundle between the pipeline (master) and pipe_ctrl_n (slave).
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_n_if #(
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 16
);
    logic [NSTAGE-1:0] stall_req;
    logic [NSTAGE-1:0] flush_req;
    logic              hold_set;
    logic              hold_release;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              hold_active;
    logic              hold_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0]  perf_stall_cyc;
    logic [CNT_W-1:0]  perf_flush_cnt;
    logic [CNT_W-1:0]  perf_hold_cyc;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_ctrl_n_if: CNT_W must be >= 1");
    end
`endif

    modport master (
        output stall_req, flush_req, hold_set, hold_release,
        input  stall, bubble, flush, hold_active, hold_err
`ifdef PIPE_CTRL_PERF_EN
        , input perf_stall_cyc, perf_flush_cnt, perf_hold_cyc
`endif
    );

    modport slave (
        input  stall_req, flush_req, hold_set, hold_release,
        output stall, bubble, flush, hold_active, hold_err
`ifdef PIPE_CTRL_PERF_EN
        , output perf_stall_cyc, perf_flush_cnt, perf_hold_cyc
`endif
    );
endinterface

// File: rtl/pipe_ctrl_prio.sv
// Highest-set-bit encoder: idx = index of the most significant set bit of req,
// vld = any bit set. Used to pick the oldest flush requester.
module pipe_ctrl_prio
    import pipe_ctrl_n_pkg::*;
#(
    parameter  int N  = 5,
    localparam int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          vld
);
    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx = '0;
        vld = FALSE;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IW'(i);
                vld = TRUE;
            end
        end
    end
endmodule

// File: rtl/pipe_ctrl_n.sv
// N-stage pipeline control: combinational stall/bubble, registered multi-cycle
// flush, sticky hold FSM with timeout flag.
// Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int NSTAGE       = int'(STG_WB) + 1,
    parameter int HOLD_STAGE   = int'(STG_EX),
    parameter int FLUSH_CYCLES = 1,
    parameter int HOLD_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_n_if.slave bus
);
    localparam int IW = $clog2(NSTAGE);
    localparam int FW = cnt_width(FLUSH_CYCLES);
    localparam int TW = cnt_width(HOLD_TIMEOUT);

    if (NSTAGE < 2 || NSTAGE > 16 || HOLD_STAGE >= NSTAGE || HOLD_STAGE < 0 ||
        FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || HOLD_TIMEOUT < 0 || CNT_W < 1) begin : g_bad_param
        $error("pipe_ctrl_n: parameter out of range");
    end

    state_e            state_q, state_d;
    logic [NSTAGE-1:0] flush_q, flush_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              herr_q, herr_d;

    logic [IW-1:0]     src_idx;
    logic              src_vld, issue, flush_act, hold_eff, acc;
    logic [NSTAGE-1:0] kill_mask, s_raw, stall_v, bubble_v;

    pipe_ctrl_prio #(.N(NSTAGE)) u_prio (
        .req (bus.flush_req),
        .idx (src_idx),
        .vld (src_vld)
    );

    // Stall = any request at this stage or older, plus the hold window; flush wins.
    always_comb begin
        hold_eff = ((state_q == ST_HOLD) && !bus.hold_release) ||
                   ((state_q == ST_RUN) && bus.hold_set && !bus.hold_release);
        acc      = FALSE;
        s_raw    = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            acc      = acc | bus.stall_req[k];
            s_raw[k] = acc | (hold_eff && (k <= HOLD_STAGE));
        end
        stall_v  = rst ? (s_raw & ~flush_q) : '0;
        bubble_v = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            bubble_v[k] = stall_v[k-1] & ~stall_v[k];
        end
    end

    // Flush: oldest requester kills all younger stages; a new request reloads
    // the counter and widens the kill range to the union.
    always_comb begin
        flush_act = (fcnt_q != '0);
        issue     = src_vld && (src_idx != '0);
        kill_mask = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            kill_mask[k] = (k < int'(src_idx));
        end
        flush_d = flush_q;
        fcnt_d  = fcnt_q;
        if (issue) begin
            flush_d = kill_mask | (flush_act ? flush_q : '0);
            fcnt_d  = FW'(FLUSH_CYCLES);
        end else if (flush_act) begin
            fcnt_d = fcnt_q - FW'(1);
            if (fcnt_d == '0) flush_d = '0;
        end
    end

    // Hold FSM and timeout; release beats set, a flush covering the hold stage aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (bus.hold_set && !bus.hold_release) state_d = ST_HOLD;
            ST_HOLD: if (bus.hold_release) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (issue && (int'(src_idx) > HOLD_STAGE)) state_d = ST_RUN;

        tcnt_d = '0;
        if (state_d == ST_HOLD) begin
            tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);
        end
        herr_d = herr_q | ((HOLD_TIMEOUT != 0) && (int'(tcnt_d) >= HOLD_TIMEOUT));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            flush_q <= '0;
            fcnt_q  <= '0;
            tcnt_q  <= '0;
            herr_q  <= FALSE;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            fcnt_q  <= fcnt_d;
            tcnt_q  <= tcnt_d;
            herr_q  <= herr_d;
        end
    end

    assign bus.stall       = stall_v;
    assign bus.bubble      = bubble_v;
    assign bus.flush       = flush_q;
    assign bus.hold_active = (state_q == ST_HOLD);
    assign bus.hold_err    = herr_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] pst_q, pst_d, pfl_q, pfl_d, phd_q, phd_d;

    // Saturating event counters.
    always_comb begin
        pst_d = pst_q;
        pfl_d = pfl_q;
        phd_d = phd_q;
        if (stall_v[0] && pst_q != '1)             pst_d = pst_q + CNT_W'(1);
        if (issue && pfl_q != '1)                  pfl_d = pfl_q + CNT_W'(1);
        if ((state_q == ST_HOLD) && phd_q != '1)   phd_d = phd_q + CNT_W'(1);
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pst_q <= '0;
            pfl_q <= '0;
            phd_q <= '0;
        end else begin
            pst_q <= pst_d;
            pfl_q <= pfl_d;
            phd_q <= phd_d;
        end
    end

    assign bus.perf_stall_cyc = pst_q;
    assign bus.perf_flush_cnt = pfl_q;
    assign bus.perf_hold_cyc  = phd_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench for pipe_ctrl_n: a driver applies directed then random
// stimulus and queues the expected outputs from a behavioural model; a monitor
// compares DUT outputs at the falling edge.
module tb_pipe_ctrl_n;
    localparam int NS = 5;
    localparam int HS = 2;
    localparam int FC = 2;
    localparam int HT = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_n_if #(.NSTAGE(NS), .CNT_W(CW)) bus ();

    pipe_ctrl_n #(
        .NSTAGE(NS), .HOLD_STAGE(HS), .FLUSH_CYCLES(FC),
        .HOLD_TIMEOUT(HT), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NS-1:0] stall;
        logic [NS-1:0] bubble;
        logic [NS-1:0] flush;
        logic          hact;
        logic          herr;
        int            pst;
        int            pfl;
        int            phd;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: hold flag, hold cycle count, sticky error,
    // remaining flush cycles and the exclusive top of the kill range.
    bit m_hold, m_err;
    int m_hcyc, m_rem, m_top;
    int m_pst, m_pfl, m_phd;

    task automatic model_reset();
        m_hold = 0; m_err = 0; m_hcyc = 0; m_rem = 0; m_top = 0;
        m_pst = 0; m_pfl = 0; m_phd = 0;
    endtask

    task automatic drive(input logic r, input logic [NS-1:0] sr, input logic [NS-1:0] fr,
                         input logic hs, input logic hr);
        exp_t e;
        bit   heff, s;
        int   o;
        @(posedge clk);
        #1;
        rst = r;
        bus.stall_req = sr;
        bus.flush_req = fr;
        bus.hold_set = hs;
        bus.hold_release = hr;
        e = '{default: 0};
        if (!r) begin
            model_reset();
        end else begin
            heff = m_hold ? !hr : (hs && !hr);
            for (int k = 0; k < NS; k++) begin
                e.flush[k] = (m_rem > 0) && (k < m_top);
                s = heff && (k <= HS);
                for (int j = k; j < NS; j++) s = s | sr[j];
                e.stall[k] = s && !e.flush[k];
            end
            for (int k = 1; k < NS; k++) e.bubble[k] = e.stall[k-1] && !e.stall[k];
            e.hact = m_hold;
            e.herr = m_err;
            e.pst = m_pst; e.pfl = m_pfl; e.phd = m_phd;
            // advance the model by one clock
            o = 0;
            for (int j = 0; j < NS; j++) if (fr[j]) o = j;
            if (e.stall[0]) m_pst++;
            if (m_hold) m_phd++;
            if (o >= 1) begin
                m_pfl++;
                m_top = (m_rem > 0 && m_top > o) ? m_top : o;
                m_rem = FC;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (o > HS)      m_hold = 0;
            else if (m_hold) m_hold = !hr;
            else             m_hold = hs && !hr;
            m_hcyc = m_hold ? m_hcyc + 1 : 0;
            if (m_hcyc >= HT) m_err = 1;
        end
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", n, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",       32'(bus.stall),       32'(e.stall));
                chk("bubble",      32'(bus.bubble),      32'(e.bubble));
                chk("flush",       32'(bus.flush),       32'(e.flush));
                chk("hold_active", 32'(bus.hold_active), 32'(e.hact));
                chk("hold_err",    32'(bus.hold_err),    32'(e.herr));
`ifdef PIPE_CTRL_PERF_EN
                chk("perf_stall_cyc", 32'(bus.perf_stall_cyc), 32'(e.pst));
                chk("perf_flush_cnt", 32'(bus.perf_flush_cnt), 32'(e.pfl));
                chk("perf_hold_cyc",  32'(bus.perf_hold_cyc),  32'(e.phd));
`endif
            end
        end
    end

    initial begin
        logic [NS-1:0] sr, fr;
        int guard;
        bus.stall_req = '0; bus.flush_req = '0;
        bus.hold_set = 1'b0; bus.hold_release = 1'b0;
        model_reset();

        // reset with live inputs: outputs must stay zero
        drive(0, 5'b11111, 5'b11111, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // single-cycle stall at stage 3
        drive(1, 5'b01000, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // hold, release three cycles later
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        // flush from stage 3, stall request at stage 1 in the window
        drive(1, 0, 5'b01000, 0, 0);
        drive(1, 5'b00010, 0, 0, 0);
        drive(1, 5'b00010, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // flush covering the hold stage aborts the hold
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 5'b01000, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0);
        // set and release together: stay in RUN
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0);
        // timeout: hold for six cycles
        drive(1, 0, 0, 1, 0);
        repeat (6) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        repeat (2) drive(1, 0, 0, 0, 0);
        // overlapping flushes widen the kill range; flush_req[0] alone is ignored
        drive(1, 0, 5'b00100, 0, 0);
        drive(1, 0, 5'b10000, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0);
        drive(1, 0, 5'b00001, 0, 0);
        drive(1, 0, 0, 0, 0);
        // reset in the middle of a flush with a hold pending
        drive(1, 0, 5'b01000, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // random phase
        for (int i = 0; i < 2000; i++) begin
            sr = ($urandom % 4 == 0) ? NS'($urandom_range(0, 31)) : '0;
            fr = ($urandom % 8 == 0) ? NS'($urandom_range(0, 31)) : '0;
            drive(($urandom % 150) != 0, sr, fr, ($urandom % 5) == 0, ($urandom % 9) == 0);
        end
        drive(1, 0, 0, 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
- Parametrised pipeline control unit for an N-stage in-order core. Replaces the single pause/flush pair with per-stage stall, bubble and flush vectors.
- Stage 0 is the youngest stage (fetch) and stage NSTAGE-1 the oldest (writeback).
- Arbitrates combinational stall requests, multi-cycle sticky holds (set/release handshake) and registered multi-cycle flushes, and flags holds that time out.

Parameters:
- NSTAGE, 5: number of pipeline stages (2..16).
- HOLD_STAGE, 2: highest stage index frozen by a sticky hold; stages 0..HOLD_STAGE stall.
- FLUSH_CYCLES, 1: cycles a flush stays asserted (1..15).
- HOLD_TIMEOUT, 255: maximum cycles in HOLD before hold_err is raised; 0 disables the timeout.
- CNT_W, 16: perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_req  in  NSTAGE  per-stage single-cycle stall request (combinational, same cycle).
- flush_req  in  NSTAGE  bit i set = stage i requests a flush of all stages younger than i.
- hold_set  in  1  starts a sticky hold (e.g. decode hazard waiting on memory).
- hold_release  in  1  ends the sticky hold (e.g. memory done).
- stall  out  NSTAGE  per-stage freeze.
- bubble  out  NSTAGE  bit k = stage k inserts a NOP into its output register.
- flush  out  NSTAGE  per-stage kill, registered.
- hold_active  out  1  FSM is in HOLD.
- hold_err  out  1  sticky timeout flag, cleared by reset only.

Behaviour:
- Reset (rst=0, async): FSM=RUN; flush, hold_err and all counters are 0. hold_active=0. stall and bubble evaluate to the all-zero-input values (0) while held in reset.
- FSM states and transitions:
  - RUN -> HOLD on hold_set & ~hold_release.
  - HOLD -> RUN on hold_release. Release wins over a simultaneous set, both in RUN and in HOLD.
  - Any state -> RUN when a flush is issued whose target range covers HOLD_STAGE; the hold is abandoned.
- Stall (combinational, zero latency):
  - s[k] = OR(stall_req[j] for j>=k) | (hold_eff & k<=HOLD_STAGE).
  - hold_eff = (state==HOLD & ~hold_release) | (state==RUN & hold_set & ~hold_release).
  - Release therefore unstalls in the same cycle, and set stalls in the same cycle.
  - stall[k] = s[k] & ~flush[k].
- Bubble: bubble[k] = stall[k-1] & ~stall[k] for k>=1; bubble[0]=0.
- Flush (registered, 1-cycle latency):
  - The oldest requesting stage o wins (highest set bit of flush_req).
  - Next cycle, flush[k]=1 for all k<o, held for FLUSH_CYCLES cycles via a down-counter.
  - A new flush_req arriving during an active flush reloads the counter. The kill range becomes the union of the active and new ranges.
  - flush_req[0] has no effect (no younger stages).
  - Flush overrides stall on the same stage; older stages keep their stall.
- Timeout:
  - An internal counter increments each HOLD cycle and saturates.
  - When it reaches HOLD_TIMEOUT (if nonzero), hold_err is set. The hold continues until release.
  - The counter clears on entering RUN.
- Reset asserted mid-hold or mid-flush: immediate return to the reset values listed above; no pending state survives.
- All vectors are NSTAGE wide. Counter widths derive from $clog2 of their parameters.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cyc, perf_flush_cnt and perf_hold_cyc, each CNT_W wide, saturating, reset to 0.
  - perf_stall_cyc counts cycles with stall[0]=1.
  - perf_flush_cnt counts issued flushes.
  - perf_hold_cyc counts HOLD cycles.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include: FSM state encodings (ST_RUN, ST_HOLD), the true/false constants already used by the core, and the default stage-index constants (STG_IF..STG_WB).
- One sub-module: pipe_ctrl_prio, a parametrised highest-set-bit encoder (NSTAGE -> index plus valid). It is used for flush source selection and is unit-testable on its own.

Test Plan (NSTAGE=5, HOLD_STAGE=2, FLUSH_CYCLES=2, HOLD_TIMEOUT=4):
- stall_req=5'b01000 for 1 cycle -> stall=5'b01111 and bubble=5'b10000 in the same cycle; all zero the next cycle.
- hold_set pulse, hold_release 3 cycles later -> hold_active=1 for 3 cycles, stall=5'b00111 during them; stall clears in the release cycle.
- flush_req=5'b01000 at cycle t -> flush=5'b00111 at t+1 and t+2, 0 at t+3; stall_req=5'b00010 during that window -> stall[1]=0.
- hold active and flush_req[3] -> next cycle FSM=RUN, hold_active=0. Also hold_set & hold_release together -> FSM stays RUN.
- Hold with no release for 6 cycles -> hold_err=1 from the 4th HOLD cycle onward, stays 1 after release until rst=0.
- rst deasserted-low mid-flush -> flush=0 and hold_active=0 asynchronously. With PIPE_CTRL_PERF_EN, all perf counters read 0 after reset.
